// File: rtl/wb_retire_buffer.sv
// In-order writeback retire buffer: aligns load data on entry, drains to a shared regfile port, forwards the youngest match.
// Optional retired-write counter enabled by defining WB_RETIRE_CNT_EN.
module wb_retire_buffer #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int REG_AW = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_wb_en,
    input  logic [REG_AW-1:0]          in_rd,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       in_is_load,
    input  logic [2:0]                 in_funct3,
    input  logic [1:0]                 in_addr_lo,
    input  logic                       rf_ready,
    output logic                       rf_we,
    output logic [REG_AW-1:0]          rf_rd,
    output logic [XLEN-1:0]            rf_wdata,
    input  logic [REG_AW-1:0]          fwd_rs1,
    input  logic [REG_AW-1:0]          fwd_rs2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [XLEN-1:0]            fwd_data1,
    output logic [XLEN-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                retired_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [REG_AW-1:0] ent_rd   [DEPTH];
    logic [XLEN-1:0]   ent_data [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              accept;
    logic              store;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   aligned;

    always_comb begin
        shifted = in_data >> {in_addr_lo, 3'b000};
        aligned = in_data;
        if (in_is_load) begin
            case (in_funct3)
                3'b000:  aligned = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
                3'b001:  aligned = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                3'b100:  aligned = {{(XLEN-8){1'b0}}, shifted[7:0]};
                3'b101:  aligned = {{(XLEN-16){1'b0}}, shifted[15:0]};
                default: aligned = in_data;
            endcase
        end
    end

    // Gating with rst keeps a reset cycle from retiring the head entry.
    assign rf_we    = rst && (occupancy != '0) && rf_ready && !flush;
    assign rf_rd    = ent_rd[head];
    assign rf_wdata = ent_data[head];
    assign in_ready = (occupancy < OW'(DEPTH)) || rf_we;
    assign accept   = in_valid && in_ready && !flush;
    assign store    = accept && in_wb_en && (in_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (rf_we) head <= head + PW'(1);
            if (store) tail <= tail + PW'(1);
            case ({store, rf_we})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && store) begin
            ent_rd[tail]   <= in_rd;
            ent_data[tail] <= aligned;
        end
    end

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = head;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (OW'(i) < occupancy) begin
                if (fwd_rs1 != '0 && ent_rd[idx] == fwd_rs1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = ent_data[idx];
                end
                if (fwd_rs2 != '0 && ent_rd[idx] == fwd_rs2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = ent_data[idx];
                end
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (rf_we) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Self-checking bench for wb_retire_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_wb_retire_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_en;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [4:0]  fwd_rs1;
    logic [4:0]  fwd_rs2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [2:0]  occupancy;
    logic [31:0] retired_cnt;

    wb_retire_buffer #(.XLEN(32), .DEPTH(4), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_wb_en(in_wb_en),
        .in_rd(in_rd), .in_data(in_data), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .occupancy(occupancy), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          wlog[$];
    int unsigned m_cnt;
    logic        exp_we;
    logic        exp_ready;
    int          vectors;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_align(input logic [31:0] d, input logic ld,
                                                input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] sh;
        logic [31:0] b;
        logic [31:0] h;
        if (!ld) return d;
        sh = d >> (8 * lo);
        b  = sh % 256;
        h  = sh % 65536;
        case (f3)
            3'd0: return (b >= 128) ? b - 32'd256 : b;
            3'd1: return (h >= 32768) ? h - 32'd65536 : h;
            3'd4: return b;
            3'd5: return h;
            default: return d;
        endcase
    endfunction

    function automatic void model_lookup(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs == 0) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rd == rs) begin
                hit = 1'b1;
                d   = q[i].data;
                return;
            end
        end
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic sample();
        logic        h;
        logic [31:0] d;
        @(negedge clk);
        exp_we    = rst && q.size() != 0 && rf_ready && !flush;
        exp_ready = (q.size() < 4) || exp_we;
        chk("occupancy", 32'(occupancy), q.size());
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("rf_we", 32'(rf_we), 32'(exp_we));
        if (exp_we) begin
            chk("rf_rd", 32'(rf_rd), 32'(q[0].rd));
            chk("rf_wdata", rf_wdata, q[0].data);
        end
        model_lookup(fwd_rs1, h, d);
        chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
        chk("fwd_data1", fwd_data1, d);
        model_lookup(fwd_rs2, h, d);
        chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
        chk("fwd_data2", fwd_data2, d);
        chk("retired_cnt", retired_cnt, exp_cnt());
    endtask

    task automatic advance();
        ent_t e;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (exp_we) begin
                wlog.push_back(int'(q[0].rd));
                void'(q.pop_front());
                m_cnt++;
            end
            if (in_valid && exp_ready && in_wb_en && in_rd != 0) begin
                e.rd   = in_rd;
                e.data = model_align(in_data, in_is_load, in_funct3, in_addr_lo);
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_wb_en   = 1'b0;
        in_rd      = '0;
        in_data    = '0;
        in_is_load = 1'b0;
        in_funct3  = '0;
        in_addr_lo = '0;
        fwd_rs1    = '0;
        fwd_rs2    = '0;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [31:0] d);
        in_valid   = 1'b1;
        in_wb_en   = 1'b1;
        in_rd      = rd;
        in_data    = d;
        in_is_load = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        sample();
        advance();
        rst = 1'b1;
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        m_cnt    = 0;
        exp_we   = 1'b0;
        rf_ready = 1'b0;
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        sample();
        chk("rst_ready", 32'(in_ready), 32'd1);
        advance();

        // LB / LBU alignment
        rf_ready = 1'b1;
        offer(5'd5, 32'h80FF_7F01);
        in_is_load = 1'b1; in_funct3 = 3'b000; in_addr_lo = 2'd3;
        sample(); advance();
        idle();
        sample();
        chk("lb_we", 32'(rf_we), 32'd1);
        chk("lb_rd", 32'(rf_rd), 32'd5);
        chk("lb_data", rf_wdata, 32'hFFFF_FF80);
        advance();
        offer(5'd5, 32'h80FF_7F01);
        in_is_load = 1'b1; in_funct3 = 3'b100; in_addr_lo = 2'd3;
        sample(); advance();
        idle();
        sample();
        chk("lbu_data", rf_wdata, 32'h0000_0080);
        advance();

        // Fill, then drain while full with a fifth accepted in the same cycle
        rf_ready = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            offer(5'(r), 32'(r * 256));
            sample(); advance();
        end
        offer(5'd5, 32'h500);
        sample();
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        advance();
        rf_ready = 1'b1;
        wlog.delete();
        sample();
        chk("full_drain_ready", 32'(in_ready), 32'd1);
        advance();
        idle();
        for (int k = 0; k < 6; k++) begin
            sample(); advance();
        end
        chk("drain_count", wlog.size(), 32'd5);
        for (int k = 0; k < 5 && k < wlog.size(); k++) chk("drain_order", wlog[k], k + 1);
        sample();
        chk("drain_empty", 32'(occupancy), 32'd0);
        advance();

        // Youngest-match forwarding
        rf_ready = 1'b0;
        offer(5'd7, 32'h11); sample(); advance();
        offer(5'd7, 32'h22); sample(); advance();
        idle();
        fwd_rs1 = 5'd7;
        fwd_rs2 = 5'd0;
        sample();
        chk("fwd_young_hit", 32'(fwd_hit1), 32'd1);
        chk("fwd_young_data", fwd_data1, 32'h22);
        chk("fwd_x0_hit", 32'(fwd_hit2), 32'd0);
        advance();

        // Consumed-but-not-stored results
        offer(5'd0, 32'hDEAD); sample(); chk("rd0_ready", 32'(in_ready), 32'd1); advance();
        offer(5'd9, 32'hBEEF); in_wb_en = 1'b0; sample(); advance();
        idle();
        sample();
        chk("nostore_occ", 32'(occupancy), 32'd2);
        advance();

        // Flush with three entries and a pending write
        offer(5'd3, 32'h33); sample(); advance();
        offer(5'd4, 32'h44);
        flush = 1'b1; rf_ready = 1'b1; fwd_rs1 = 5'd7;
        sample();
        chk("flush_we", 32'(rf_we), 32'd0);
        advance();
        idle();
        fwd_rs1 = 5'd7;
        sample();
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_hit", 32'(fwd_hit1), 32'd0);
        advance();

        // Retire counter across reset
        do_reset();
        rf_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            offer(5'(k + 10), 32'(k)); sample(); advance();
        end
        idle();
        sample(); advance();
        sample();
`ifdef WB_RETIRE_CNT_EN
        chk("cnt_before", retired_cnt, 32'd6);
`else
        chk("cnt_before", retired_cnt, 32'd0);
`endif
        advance();
        do_reset();
        sample();
        chk("cnt_after", retired_cnt, 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        advance();

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            rst        = ($urandom_range(59) != 0);
            flush      = ($urandom_range(24) == 0);
            in_valid   = $urandom_range(1);
            in_wb_en   = ($urandom_range(4) != 0);
            in_rd      = 5'($urandom_range(7));
            in_data    = $urandom;
            in_is_load = $urandom_range(1);
            in_funct3  = 3'($urandom_range(7));
            in_addr_lo = 2'($urandom_range(3));
            rf_ready   = ($urandom_range(9) < 6);
            fwd_rs1    = 5'($urandom_range(7));
            fwd_rs2    = 5'($urandom_range(7));
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wb_retire_buffer.md
Name: wb_retire_buffer

Overview:
- Parametrised next-generation writeback stage for the rv32i pipeline.
- Accepts MEM-stage results through a valid/ready handshake and aligns and sign-extends load data on entry.
- Holds results in a DEPTH-entry in-order buffer and drains them to a shared regfile write port when the port is granted.
- Provides youngest-match forwarding of buffered results to ID/EXE. Lets MEM advance while the regfile port is contended.

Parameters:
- XLEN, 32, data width of results and regfile.
- DEPTH, 4, buffer entries; power of two, minimum 2.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  discard all buffered, unwritten entries.
- in_valid  in  1  MEM result offered.
- in_ready  out  1  buffer accepts the offered result this cycle.
- in_wb_en  in  1  result writes a register.
- in_rd  in  REG_AW  destination register.
- in_data  in  XLEN  ALU result or raw load word.
- in_is_load  in  1  in_data is a load word that needs alignment.
- in_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- in_addr_lo  in  2  low address bits of the load.
- rf_ready  in  1  regfile write port granted this cycle.
- rf_we  out  1  regfile write strobe.
- rf_rd  out  REG_AW  regfile write index.
- rf_wdata  out  XLEN  regfile write data.
- fwd_rs1, fwd_rs2  in  REG_AW  source registers to look up.
- fwd_hit1, fwd_hit2  out  1  a buffered entry matches the source register.
- fwd_data1, fwd_data2  out  XLEN  data of the youngest matching entry.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.
- retired_cnt  out  32  count of completed regfile writes (optional feature).

Behaviour:
- Reset (rst=0 at a clock edge): head, tail and occupancy go to 0 and all entries become invalid. rf_we=0, fwd_hit*=0, in_ready=1 on the next cycle.
- Accept: when in_valid && in_ready. If in_wb_en=0 or in_rd=0, the result is consumed but not stored (no occupancy change).
- Store: otherwise write {rd, aligned data} at tail, tail+1 mod DEPTH.
- Load alignment:
  - Shift in_data right by 8*in_addr_lo.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
  - LW uses the word unchanged.
  - Other funct3 values store the raw word.
  - Non-loads store in_data unchanged.
- Drain: rf_we = occupancy!=0 && rf_ready && !flush. rf_rd and rf_wdata come from the head entry. When rf_we=1, head advances at the edge.
- Latency: an accepted entry can be written no earlier than the cycle after acceptance. There is no same-cycle bypass to the regfile.
- in_ready = (occupancy<DEPTH) || rf_we. When the buffer is full and draining, a store is accepted in the same cycle.
- Simultaneous accept and drain: occupancy is unchanged and both pointers advance. With DEPTH=2 and occupancy=DEPTH, data ordering is preserved.
- Wrap-around: pointers are modulo DEPTH. Occupancy distinguishes full from empty.
- Forwarding (combinational):
  - Scan valid entries, youngest (tail-1) first.
  - The first entry with rd==fwd_rsX gives hit=1 and its data.
  - fwd_rsX=0 always gives hit=0. No match gives hit=0 and data=0.
  - The incoming, not-yet-accepted result is not forwarded.
- Flush: at the edge all entries are invalidated, pointers and occupancy go to 0. No regfile write occurs in the flush cycle, and any in_valid that cycle is dropped. Flush has priority over accept and drain; reset has priority over flush.
- Reset mid-drain: no write is issued in the reset cycle.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - retired_cnt increments by 1 on each cycle with rf_we=1, wraps at 2^32, and resets to 0.
  - The counter is unaffected by flush.
- Undefined: retired_cnt is tied to 0 and no counter register exists.

Test Plan:
- LB, in_data=0x80FF_7F01, addr_lo=3, rd=5, rf_ready=1 -> the next cycle gives rf_we=1, rf_rd=5, rf_wdata=0xFFFF_FF80. LBU with the same inputs -> 0x0000_0080.
- Four stores with rd=1..4 and rf_ready=0 -> occupancy=4 and in_ready=0. Raising rf_ready with a fifth offer -> in_ready=1; writes drain in order 1,2,3,4,5; occupancy ends at 0.
- Buffer holds rd=7 twice (0x11 then 0x22), fwd_rs1=7 -> fwd_hit1=1, fwd_data1=0x22. fwd_rs2=0 -> fwd_hit2=0.
- in_rd=0, or in_wb_en=0, with in_valid=1 -> in_ready=1, occupancy unchanged, no rf_we.
- Three entries buffered, flush=1 with rf_ready=1 -> rf_we=0 that cycle, occupancy=0 next cycle, fwd hits clear.
- With WB_RETIRE_CNT_EN, 6 writes then rst=0 for one cycle -> retired_cnt reads 6 before reset and 0 after, and occupancy=0.
